// File: rtl/fmac_operand_unpack_pipe.sv
// Two-stage elastic operand unpacker for the FMAC datapath: stage 1 splits and classifies
// each packed IEEE-754 operand, stage 2 pre-normalises denormals so consumers see 1.x mantissas.
module fmac_operand_unpack_pipe #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MANT_W  = 23,
    parameter int unsigned NUM_OPS = 3,
    parameter int unsigned TAG_W   = 4,
    localparam int unsigned OP_W   = 1 + EXP_W + MANT_W,
    localparam int unsigned XE_W   = EXP_W + 2
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic                          Flush_SI,
    input  logic                          In_valid_SI,
    output logic                          In_ready_SO,
    input  logic                          Ftz_SI,
    input  logic [NUM_OPS*OP_W-1:0]       Operands_DI,
    input  logic [TAG_W-1:0]              Tag_DI,
    output logic                          Out_valid_SO,
    input  logic                          Out_ready_SI,
    output logic [NUM_OPS-1:0]            Sign_DO,
    output logic [NUM_OPS*XE_W-1:0]       Exp_DO,
    output logic [NUM_OPS*(MANT_W+1)-1:0] Mant_DO,
    output logic [NUM_OPS-1:0]            Zero_SO,
    output logic [NUM_OPS-1:0]            Inf_SO,
    output logic [NUM_OPS-1:0]            NaN_SO,
    output logic [NUM_OPS-1:0]            SNaN_SO,
    output logic [NUM_OPS-1:0]            DeN_SO,
    output logic [TAG_W-1:0]              Tag_DO
);

    localparam int unsigned LZ_W = $clog2(MANT_W + 1);

    // Leading zeros of a non-zero stored mantissa; result lies in 0..MANT_W-1.
    function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] m);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n     = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    logic v1_q, v1_d, v2_q, v2_d;
    logic s2_rdy, accept, move;

    logic [NUM_OPS-1:0]              s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d, s1_den_q, s1_den_d;
    logic [NUM_OPS-1:0]              s1_inf_q, s1_inf_d, s1_nan_q, s1_nan_d, s1_snan_q, s1_snan_d;
    logic [NUM_OPS-1:0][EXP_W-1:0]   s1_exp_q, s1_exp_d;
    logic [NUM_OPS-1:0][MANT_W-1:0]  s1_mant_q, s1_mant_d;
    logic [TAG_W-1:0]                s1_tag_q, s1_tag_d;

    logic [NUM_OPS-1:0]              s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d, s2_den_q, s2_den_d;
    logic [NUM_OPS-1:0]              s2_inf_q, s2_inf_d, s2_nan_q, s2_nan_d, s2_snan_q, s2_snan_d;
    logic [NUM_OPS-1:0][XE_W-1:0]    s2_exp_q, s2_exp_d;
    logic [NUM_OPS-1:0][MANT_W:0]    s2_mant_q, s2_mant_d;
    logic [TAG_W-1:0]                s2_tag_q, s2_tag_d;

    // Flush wins over any simultaneous accept or stage move.
    always_comb begin
        s2_rdy      = ~v2_q | Out_ready_SI;
        In_ready_SO = (~v1_q | s2_rdy) & ~Flush_SI;
        accept      = In_valid_SI & In_ready_SO;
        move        = v1_q & s2_rdy;
        v1_d        = Flush_SI ? 1'b0 : (accept | (v1_q & ~move));
        v2_d        = Flush_SI ? 1'b0 : (move | (v2_q & ~Out_ready_SI));
    end

    always_comb begin
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        // NOTE: every comb output starts from a hold/default value so no path can infer a latch.
        e         = '0;
        m         = '0;
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_den_d  = s1_den_q;
        s1_inf_d  = s1_inf_q;
        s1_nan_d  = s1_nan_q;
        s1_snan_d = s1_snan_q;
        s1_exp_d  = s1_exp_q;
        s1_mant_d = s1_mant_q;
        s1_tag_d  = s1_tag_q;
        if (accept) begin
            s1_tag_d = Tag_DI;
            for (int k = 0; k < NUM_OPS; k++) begin
                e = Operands_DI[k*OP_W+MANT_W +: EXP_W];
                m = Operands_DI[k*OP_W +: MANT_W];
                s1_sign_d[k] = Operands_DI[k*OP_W+OP_W-1];
                s1_exp_d[k]  = e;
                s1_mant_d[k] = m;
                // Flush-to-zero folds a denormal into the zero class, keeping its sign.
                s1_zero_d[k] = ~|e & (~|m | Ftz_SI);
                s1_den_d[k]  = ~|e & |m & ~Ftz_SI;
                s1_inf_d[k]  = &e & ~|m;
                s1_nan_d[k]  = &e & |m;
                s1_snan_d[k] = &e & |m & ~m[MANT_W-1];
            end
        end
    end

    always_comb begin
        logic [LZ_W-1:0] lz;
        lz        = '0;
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_den_d  = s2_den_q;
        s2_inf_d  = s2_inf_q;
        s2_nan_d  = s2_nan_q;
        s2_snan_d = s2_snan_q;
        s2_exp_d  = s2_exp_q;
        s2_mant_d = s2_mant_q;
        s2_tag_d  = s2_tag_q;
        if (move) begin
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            s2_den_d  = s1_den_q;
            s2_inf_d  = s1_inf_q;
            s2_nan_d  = s1_nan_q;
            s2_snan_d = s1_snan_q;
            s2_tag_d  = s1_tag_q;
            for (int k = 0; k < NUM_OPS; k++) begin
                lz = lzc(s1_mant_q[k]);
                if (s1_zero_q[k]) begin
                    s2_exp_d[k]  = '0;
                    s2_mant_d[k] = '0;
                end else if (s1_den_q[k]) begin
                    s2_exp_d[k]  = -XE_W'(lz);
                    s2_mant_d[k] = {1'b0, s1_mant_q[k]} << (lz + LZ_W'(1));
                end else begin
                    s2_exp_d[k]  = XE_W'(s1_exp_q[k]);
                    s2_mant_d[k] = {1'b1, s1_mant_q[k]};
                end
            end
        end
    end

    // NOTE: the data registers are reset too, so outputs read as zero after reset, not stale.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_sign_q <= '0; s1_zero_q <= '0; s1_den_q  <= '0; s1_inf_q <= '0;
            s1_nan_q  <= '0; s1_snan_q <= '0; s1_exp_q  <= '0; s1_mant_q <= '0;
            s1_tag_q  <= '0;
            s2_sign_q <= '0; s2_zero_q <= '0; s2_den_q  <= '0; s2_inf_q <= '0;
            s2_nan_q  <= '0; s2_snan_q <= '0; s2_exp_q  <= '0; s2_mant_q <= '0;
            s2_tag_q  <= '0;
        end else begin
            // NOTE: non-blocking updates let every flop sample pre-edge values together.
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_sign_q <= s1_sign_d; s1_zero_q <= s1_zero_d; s1_den_q  <= s1_den_d; s1_inf_q <= s1_inf_d;
            s1_nan_q  <= s1_nan_d;  s1_snan_q <= s1_snan_d; s1_exp_q  <= s1_exp_d; s1_mant_q <= s1_mant_d;
            s1_tag_q  <= s1_tag_d;
            s2_sign_q <= s2_sign_d; s2_zero_q <= s2_zero_d; s2_den_q  <= s2_den_d; s2_inf_q <= s2_inf_d;
            s2_nan_q  <= s2_nan_d;  s2_snan_q <= s2_snan_d; s2_exp_q  <= s2_exp_d; s2_mant_q <= s2_mant_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    assign Out_valid_SO = v2_q;
    assign Sign_DO      = s2_sign_q;
    assign Exp_DO       = s2_exp_q;
    assign Mant_DO      = s2_mant_q;
    assign Zero_SO      = s2_zero_q;
    assign Inf_SO       = s2_inf_q;
    assign NaN_SO       = s2_nan_q;
    assign SNaN_SO      = s2_snan_q;
    assign DeN_SO       = s2_den_q;
    assign Tag_DO       = s2_tag_q;

endmodule
